// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry path: key codes, entry FSM states,
// display source encoding and the per-operand register control bundle.
package keypad_pkg;

   localparam logic [3:0] KEY_PLUS = 4'hA;
   localparam logic [3:0] KEY_CLR  = 4'hD;
   localparam logic [3:0] KEY_EQ   = 4'hE;

   typedef enum logic [1:0] {
      ENTER_A  = 2'd0,
      ENTER_B  = 2'd1,
      WAIT_RES = 2'd2,
      SHOW_RES = 2'd3
   } entry_state_t;

   typedef enum logic [1:0] {
      DISP_A   = 2'd0,
      DISP_B   = 2'd1,
      DISP_RES = 2'd2
   } disp_sel_t;

   // clr and load may be combined: load wins and leaves a single digit.
   typedef struct packed {
      logic clr;
      logic load;
      logic shift;
   } entry_ctl_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// One BCD operand: left-shifting digit register with a saturating digit count.
// value_d_o exposes the next value so the parent can register derived outputs.
module bcd_entry_reg
   import keypad_pkg::*;
#(
   parameter int N_DIGITS = 3,
   parameter int OW       = 4 * N_DIGITS
) (
   input  logic          clk,
   input  logic          n_reset,
   input  entry_ctl_t    ctl_i,
   input  logic [3:0]    digit_i,
   output logic [OW-1:0] value_o,
   output logic [OW-1:0] value_d_o
);

   localparam int CW = $clog2(N_DIGITS + 1);

   logic [OW-1:0] value_q, value_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      value_d = value_q;
      count_d = count_q;
      if (ctl_i.clr) begin
         value_d = '0;
         count_d = '0;
      end
      if (ctl_i.load) begin
         value_d = OW'(digit_i);
         count_d = CW'(1);
      end else if (ctl_i.shift && (count_q < CW'(N_DIGITS))) begin
         // Once full, further digits are dropped rather than wrapping.
         value_d = OW'({value_q, digit_i});
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         value_q <= '0;
         count_q <= '0;
      end else begin
         value_q <= value_d;
         count_q <= count_d;
      end
   end

   assign value_o   = value_q;
   assign value_d_o = value_d;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: builds BCD operands A and B from key strobes, hands
// them to the adder over req/ack, then holds the sum for the display path.
module keypad_entry_ctrl
   import keypad_pkg::*;
#(
   parameter int N_DIGITS = 3,
   parameter int RW       = 4 * (N_DIGITS + 1)
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic [3:0]            key_code,
   input  logic                  key_valid,
   output logic [4*N_DIGITS-1:0] operand_a,
   output logic [4*N_DIGITS-1:0] operand_b,
   output logic                  add_req,
   input  logic                  add_ack,
   input  logic [RW-1:0]         add_result,
   output logic [RW-1:0]         disp_value,
   output logic [1:0]            disp_sel,
   output logic                  busy
);

   localparam int OW = 4 * N_DIGITS;

   entry_state_t  state_q, state_d;
   logic [RW-1:0] result_q, result_d;
   logic [RW-1:0] disp_value_q, disp_value_d;
   disp_sel_t     disp_sel_q, disp_sel_d;
   logic          add_req_q, add_req_d;
   logic          busy_q, busy_d;

   entry_ctl_t    a_ctl, b_ctl;
   logic [OW-1:0] a_q, a_d, b_q, b_d;

   bcd_entry_reg #(.N_DIGITS(N_DIGITS), .OW(OW)) u_reg_a (
      .clk       (clk),
      .n_reset   (n_reset),
      .ctl_i     (a_ctl),
      .digit_i   (key_code),
      .value_o   (a_q),
      .value_d_o (a_d)
   );

   bcd_entry_reg #(.N_DIGITS(N_DIGITS), .OW(OW)) u_reg_b (
      .clk       (clk),
      .n_reset   (n_reset),
      .ctl_i     (b_ctl),
      .digit_i   (key_code),
      .value_o   (b_q),
      .value_d_o (b_d)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      a_ctl    = '0;
      b_ctl    = '0;
      case (state_q)
         ENTER_A, ENTER_B: begin
            if (key_valid) begin
               if (is_digit(key_code)) begin
                  if (state_q == ENTER_A) a_ctl.shift = 1'b1;
                  else                    b_ctl.shift = 1'b1;
               end else if (key_code == KEY_PLUS && state_q == ENTER_A) begin
                  b_ctl.clr = 1'b1;
                  state_d   = ENTER_B;
               end else if (key_code == KEY_EQ && state_q == ENTER_B) begin
                  state_d = WAIT_RES;
               end else if (key_code == KEY_CLR) begin
                  a_ctl.clr = 1'b1;
                  b_ctl.clr = 1'b1;
                  state_d   = ENTER_A;
               end
            end
         end
         // Keys are deliberately dropped here: the request must survive until ack.
         WAIT_RES: begin
            if (add_ack && add_req_q) begin
               result_d = add_result;
               state_d  = SHOW_RES;
            end
         end
         SHOW_RES: begin
            if (key_valid) begin
               if (is_digit(key_code)) begin
                  a_ctl.clr  = 1'b1;
                  a_ctl.load = 1'b1;
                  b_ctl.clr  = 1'b1;
                  state_d    = ENTER_A;
               end else if (key_code == KEY_CLR) begin
                  a_ctl.clr = 1'b1;
                  b_ctl.clr = 1'b1;
                  state_d   = ENTER_A;
               end
            end
         end
         default: state_d = ENTER_A;
      endcase
   end

   // Outputs are decoded from next-state values so they land with the state change.
   always_comb begin
      disp_value_d = RW'(a_d);
      disp_sel_d   = DISP_A;
      case (state_d)
         ENTER_B, WAIT_RES: begin
            disp_value_d = RW'(b_d);
            disp_sel_d   = DISP_B;
         end
         SHOW_RES: begin
            disp_value_d = result_d;
            disp_sel_d   = DISP_RES;
         end
         default: ;
      endcase
      add_req_d = (state_d == WAIT_RES);
      busy_d    = (state_d == WAIT_RES);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q      <= ENTER_A;
         result_q     <= '0;
         disp_value_q <= '0;
         disp_sel_q   <= DISP_A;
         add_req_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         result_q     <= result_d;
         disp_value_q <= disp_value_d;
         disp_sel_q   <= disp_sel_d;
         add_req_q    <= add_req_d;
         busy_q       <= busy_d;
      end
   end

   assign operand_a  = a_q;
   assign operand_b  = b_q;
   assign add_req    = add_req_q;
   assign busy       = busy_q;
   assign disp_value = disp_value_q;
   assign disp_sel   = disp_sel_q;

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencer between the keypad scan/debounce front end and the arithmetic/display datapath. It consumes one-cycle key strobes carrying 4-bit key codes, assembles two multi-digit BCD operands, and hands them to the adder over a req/ack handshake. It then holds the result for the 7-segment display path and decides what each later key press means in every phase of an entry.

## Interface
Parameters:
- N_DIGITS, 3, BCD digits per operand; operand width OW = 4*N_DIGITS.
- RW, 4*(N_DIGITS+1), result width in BCD bits; one extra digit holds the carry.

Ports:
- clk  in  1  system clock, 27 MHz.
- n_reset  in  1  asynchronous, active-low reset.
- key_code  in  4  key code: 0x0-0x9 digits, 0xA '+', 0xD '*' (clear), 0xE '#' ('='), 0xB/0xC/0xF unused.
- key_valid  in  1  one-cycle strobe; key_code is valid only in this cycle.
- operand_a  out  OW  BCD operand A.
- operand_b  out  OW  BCD operand B.
- add_req  out  1  request to adder; operands are stable while it is high.
- add_ack  in  1  one-cycle acknowledge from the adder, with add_result valid.
- add_result  in  RW  BCD sum.
- disp_value  out  RW  BCD value to be shown.
- disp_sel  out  2  source of disp_value: 0 = A, 1 = B, 2 = result.
- busy  out  1  high in WAIT_RES.

## Operation
- States: ENTER_A, ENTER_B, WAIT_RES, SHOW_RES. The reset state is ENTER_A.
- Digit key in ENTER_A or ENTER_B:
  - The active operand shifts left one digit, and the new digit enters at the LSD.
  - When N_DIGITS digits have already been entered, further digits are ignored; the operand does not wrap.
  - A per-operand digit counter saturates at N_DIGITS.
- '+' in ENTER_A: go to ENTER_B and set B = 0. '+' in any other state: ignored.
- '=' in ENTER_B: go to WAIT_RES and assert add_req. '=' in ENTER_A: ignored.
- '*' in ENTER_A, ENTER_B or SHOW_RES: set A = B = 0, reset the digit counters, go to ENTER_A.
- WAIT_RES:
  - All keys are ignored, including '*', because add_req must not be dropped before add_ack.
  - On add_ack: capture add_result into the result register, deassert add_req, go to SHOW_RES.
- SHOW_RES:
  - A digit key clears A and B, loads the digit as the LSD of A, and goes to ENTER_A.
  - '+' and '=' are ignored.
- disp_sel / disp_value by state:
  - ENTER_A: A, zero-extended.
  - ENTER_B: B, zero-extended.
  - WAIT_RES: B.
  - SHOW_RES: the result register.
- Unused key codes are ignored in every state.
- key_code is never sampled when key_valid is low.

## Timing
- Reset values: operand_a = 0, operand_b = 0, add_req = 0, disp_value = 0, disp_sel = 0, busy = 0, state ENTER_A.
- All outputs are registered. Every effect of key_valid in cycle N is visible in cycle N+1.
- add_req rises the cycle after the '=' strobe.
- add_req stays high through every cycle up to and including the add_ack cycle, and falls in the cycle after add_ack.
- add_result is sampled only in a cycle where add_req and add_ack are both high. add_ack outside WAIT_RES is ignored.
- If key_valid and add_ack coincide in WAIT_RES, only the ack takes effect; the key is dropped.
- Reset asserted mid-operation, including during WAIT_RES, clears everything immediately and asynchronously. The adder must tolerate add_req dropping without an ack.
- Back-to-back key_valid strobes on consecutive cycles are each processed.

## Structure
- Shared package keypad_pkg holds:
  - key code constants: KEY_PLUS = 4'hA, KEY_CLR = 4'hD, KEY_EQ = 4'hE;
  - the is_digit function (code <= 9);
  - the entry_state_t enum;
  - the disp_sel encoding.
- The lecture front end and the display driver import the same package.
- Sub-module bcd_entry_reg: one OW-bit BCD shift register with saturating digit count and clear/load controls. The controller instantiates it twice, once for A and once for B.

## Test plan
- Reset, then keys 1, 2, 3, 4:
  - operand_a = 0x123;
  - the 4 is ignored;
  - disp_sel = 0 and disp_value = 0x0123.
- Keys 4, 5, '+', 7, 8, 9, '=':
  - operand_a = 0x045, operand_b = 0x789;
  - add_req rises one cycle after the '=' strobe.
- Bench holds add_ack off for 10 cycles, then pulses it with add_result = 0x0834:
  - add_req stays high for all 10 cycles;
  - add_req falls the cycle after the ack;
  - disp_value = 0x0834, disp_sel = 2.
- Keys '*', 5, '+' and a stray '=' while in WAIT_RES:
  - no change to state or operands;
  - all keys are dropped, including the '=' that lands in the ack cycle.
- From SHOW_RES, key 6: state ENTER_A, operand_a = 0x006, operand_b = 0. Then key '*': all zero.
- Entries 9, 9, 9, '+', 9, 9, 9, '=', then n_reset pulsed low mid-WAIT_RES:
  - add_req drops asynchronously;
  - all outputs return to their reset values.
